sa_fifo_ctrl_16x14: RTL and testbench
=====================================

# sa_fifo_ctrl_16x14

Flow-controlled FIFO controller that drives the 16-entry × 14-bit two-port RAM macro with registered read address and output register, and presents it as a valid/ready FIFO. It generates the write port (`wa`/`we`/`di`) and the read port (`ra`/`re`/`ore`), absorbs the macro's two-cycle read pipeline, and buffers read data in a small output skid so the consumer can stall freely. The block sits directly in front of the RAM; the upstream producer and downstream consumer see only the handshakes.

## Interface
Parameters:
- `DEPTH`, 16: RAM entries.
- `AW`, 4: RAM address width; log2(`DEPTH`).
- `WIDTH`, 14: payload width.
- `SKID_DEPTH`, 3: output skid entries; equals the read round-trip, so full rate is sustained.

Ports:
- `nvdla_core_clk`  in  1  clock; all state on the rising edge.
- `nvdla_core_rstn`  in  1  asynchronous, active-low reset.
- `wr_pvld`  in  1  producer valid.
- `wr_prdy`  out  1  controller ready.
- `wr_pd`  in  `WIDTH`  write payload.
- `rd_pvld`  out  1  output valid.
- `rd_prdy`  in  1  consumer ready.
- `rd_pd`  out  `WIDTH`  head-of-skid payload.
- `ram_wa`  out  `AW`  RAM write address.
- `ram_we`  out  1  RAM write enable.
- `ram_di`  out  `WIDTH`  RAM write data.
- `ram_ra`  out  `AW`  RAM read address.
- `ram_re`  out  1  RAM read-address capture enable.
- `ram_ore`  out  1  RAM output-register enable.
- `ram_dout`  in  `WIDTH`  RAM registered read data.
- `fifo_count`  out  5  total entries held: RAM, in flight and skid; 0..19.
- `fifo_err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- **Write accept.** Accept when `wr_pvld && wr_prdy`. In that cycle, combinationally: `ram_we`=1, `ram_wa`=`wr_ptr`, `ram_di`=`wr_pd`. Then `wr_ptr` increments mod 16 and `ram_cnt` increments.
- **Write ready.** `wr_prdy` is registered. It is 1 iff `ram_cnt` of the next cycle is less than 16.
- **Read issue.** Issue in cycle t when `ram_cnt != 0` and `p1_vld + p2_vld + skid_cnt - pop < SKID_DEPTH`, where `pop = rd_pvld && rd_prdy`. On issue: `ram_re`=1, `ram_ra`=`rd_ptr`, `rd_ptr` increments mod 16, and `ram_cnt` decrements.
- **Slot reuse.** The RAM slot frees at the end of the issue cycle. It can be rewritten from t+1; RAM read-before-write on the same edge keeps the data correct.
- **Read pipeline.** `p1_vld` is registered from issue and `ram_ore = p1_vld`. `p2_vld` is registered from `p1_vld`. When `p2_vld`=1, `ram_dout` is pushed into the skid at that cycle's edge.
- **Output.** `rd_pvld = (skid_cnt != 0)` and `rd_pd` = skid head.
- **Simultaneous write and issue.** `ram_cnt` is unchanged. An entry written in cycle t is never issued before t+1.
- **Simultaneous skid push and pop.** Both are allowed. A push into a full skid cannot occur, because the issue rule guarantees it.
- **Counts.** `fifo_count = ram_cnt + p1_vld + p2_vld + skid_cnt`, registered. The bound is 19.
- **Pointer wrap.** Pointers wrap 15→0.

## Timing
- **Reset values.** On reset assertion, all state clears immediately: pointers, counts, `p1_vld`, `p2_vld` and skid all go to 0. Outputs then read `wr_prdy`=0, `rd_pvld`=0, `ram_we`=0, `ram_re`=0, `ram_ore`=0, `fifo_count`=0 and `fifo_err`=0. `rd_pd`, `ram_di`, `ram_wa` and `ram_ra` are 0.
- **After reset.** `wr_prdy` rises in the first clock after `nvdla_core_rstn` deasserts.
- **Reset mid-operation.** In-flight and buffered data are discarded. RAM contents are not cleared and are not relied on.
- **Latency.** Write accepted at t into an empty FIFO → issue at t+1 → `ram_ore` at t+2 → `rd_pvld` at t+4. Issue to `rd_pvld` is 3 cycles.
- **Throughput.** With `rd_prdy` held high, sustained throughput is 1 transfer per cycle.
- **Consumer stall.** With `rd_prdy` low, issue stops once 3 entries are outstanding. Accepts then continue until `ram_cnt`=16, where `fifo_count` reaches 19.

## Configuration
- **Macro:** `SA_FIFO_CTRL_ERR_EN`.
- **With the macro:** `fifo_err` is set when `wr_pvld` was 1 and `wr_prdy` was 0 in cycle t, and `wr_pvld` is 0 in cycle t+1 (valid withdrawn without accept). The flag is sticky and cleared only by reset.
- **Without the macro:** `fifo_err` is tied to 0 and no detection logic is built.

## Structure
- **Package `sa_fifo_ctrl_pkg`:**
  - `DEPTH`, `AW`, `WIDTH`, `SKID_DEPTH`.
  - Typedefs `sa_pd_t` (14 bits), `sa_addr_t` (4 bits), `sa_cnt_t` (5 bits).
- **Sub-module `sa_fifo_skid`:** a `SKID_DEPTH`-entry flop FIFO with push/pop, head data and occupancy count. It is instantiated once for the output buffer.

## Test plan
- **Reset release:** hold reset, release → `wr_prdy`=0 in the release cycle, 1 next cycle; `rd_pvld`=0 and `fifo_count`=0.
- **Single entry:** write 0x2A5F at t with `rd_prdy`=1 → `ram_we`/`ram_wa`=0 at t, `ram_re` at t+1, `ram_ore` at t+2, `rd_pvld` with `rd_pd`=0x2A5F at t+4.
- **Fill with consumer stalled:** write values 1..19 with `rd_prdy`=0 → `wr_prdy` drops after the 19th accept and `fifo_count`=19. Then drain → outputs 1..19 in order with no bubbles once `rd_pvld` is first high.
- **Streaming wrap:** 40 back-to-back writes with `rd_prdy`=1 → output matches input order, pointers wrap twice, one output per cycle in steady state.
- **Random backpressure:** 30% `rd_prdy` low, 50% `wr_pvld` → no loss or duplication; the skid never overflows.
- **Protocol error (macro on):** `wr_pvld`=1 while full, dropped the next cycle → `fifo_err`=1 and it stays 1 until reset. With the macro off, `fifo_err` stays 0.

Source files
------------

// File: rtl/sa_fifo_ctrl_pkg.sv
// Shared sizes and types for the 16x14 RAM-backed FIFO controller.
package sa_fifo_ctrl_pkg;

  localparam int DEPTH      = 16;
  localparam int AW         = 4;
  localparam int WIDTH      = 14;
  localparam int SKID_DEPTH = 3;

  typedef logic [WIDTH-1:0] sa_pd_t;
  typedef logic [AW-1:0]    sa_addr_t;
  typedef logic [4:0]       sa_cnt_t;

  function automatic logic [1:0] skid_ptr_inc(input logic [1:0] p);
    return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/sa_fifo_skid.sv
// Small flop FIFO that holds RAM read data until the consumer takes it.
module sa_fifo_skid
  import sa_fifo_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  sa_pd_t     push_data_i,
  input  logic       pop_i,
  output sa_pd_t     head_o,
  output logic [1:0] count_o
);

  sa_pd_t     mem_q [SKID_DEPTH];
  logic [1:0] rd_ptr_q, wr_ptr_q, cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= skid_ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= skid_ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/sa_fifo_ctrl_16x14.sv
// Valid/ready FIFO front-end for a 16x14 two-port RAM with a two-cycle read.
// Optional sticky protocol-error detection: define SA_FIFO_CTRL_ERR_EN.
module sa_fifo_ctrl_16x14
  import sa_fifo_ctrl_pkg::*;
(
  input  logic     nvdla_core_clk,
  input  logic     nvdla_core_rstn,
  input  logic     wr_pvld,
  output logic     wr_prdy,
  input  sa_pd_t   wr_pd,
  output logic     rd_pvld,
  input  logic     rd_prdy,
  output sa_pd_t   rd_pd,
  output sa_addr_t ram_wa,
  output logic     ram_we,
  output sa_pd_t   ram_di,
  output sa_addr_t ram_ra,
  output logic     ram_re,
  output logic     ram_ore,
  input  sa_pd_t   ram_dout,
  output sa_cnt_t  fifo_count,
  output logic     fifo_err
);

  sa_addr_t   wr_ptr_q, rd_ptr_q;
  sa_cnt_t    ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic       wr_prdy_q, p1_q, p2_q;
  logic [1:0] skid_cnt, skid_cnt_d;
  logic [2:0] outstanding;
  logic       accept, issue, pop;

  assign accept = wr_pvld & wr_prdy_q;
  assign pop    = rd_pvld & rd_prdy;

  // Reads in flight plus skid occupancy, net of this cycle's pop, bound the skid.
  assign outstanding = {2'b0, p1_q} + {2'b0, p2_q} + {1'b0, skid_cnt} - {2'b0, pop};
  assign issue       = (ram_cnt_q != '0) && (outstanding < 3'(SKID_DEPTH));

  assign ram_cnt_d  = ram_cnt_q + {4'b0, accept} - {4'b0, issue};
  assign skid_cnt_d = skid_cnt + {1'b0, p2_q} - {1'b0, pop};
  assign count_d    = ram_cnt_d + {4'b0, issue} + {4'b0, p1_q} + {3'b0, skid_cnt_d};

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      wr_prdy_q <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      wr_prdy_q <= (ram_cnt_d < 5'(DEPTH));
      p1_q      <= issue;
      p2_q      <= p1_q;
    end
  end

  sa_fifo_skid u_skid (
    .clk_i       (nvdla_core_clk),
    .rst_ni      (nvdla_core_rstn),
    .push_i      (p2_q),
    .push_data_i (ram_dout),
    .pop_i       (pop),
    .head_o      (rd_pd),
    .count_o     (skid_cnt)
  );

  assign wr_prdy    = wr_prdy_q;
  assign rd_pvld    = (skid_cnt != '0);
  assign ram_we     = accept;
  assign ram_wa     = wr_ptr_q;
  assign ram_di     = accept ? wr_pd : '0;
  assign ram_re     = issue;
  assign ram_ra     = rd_ptr_q;
  assign ram_ore    = p1_q;
  assign fifo_count = count_q;

`ifdef SA_FIFO_CTRL_ERR_EN
  logic blocked_q, err_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      blocked_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      blocked_q <= wr_pvld & ~wr_prdy_q;
      if (blocked_q & ~wr_pvld) err_q <= 1'b1;
    end
  end

  assign fifo_err = err_q;
`else
  assign fifo_err = 1'b0;
`endif

endmodule

// File: tb/tb_sa_fifo_ctrl_16x14.sv
// Scoreboard bench for sa_fifo_ctrl_16x14 with a behavioural RAM macro model.
module tb_sa_fifo_ctrl_16x14;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [13:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [3:0]  ram_wa, ram_ra;
  logic        ram_we, ram_re, ram_ore, fifo_err;
  logic [4:0]  fifo_count;

  sa_fifo_ctrl_16x14 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_ore         (ram_ore),
    .ram_dout        (ram_dout),
    .fifo_count      (fifo_count),
    .fifo_err        (fifo_err)
  );

  always #5 clk = ~clk;

  // RAM macro: registered read address, output register, read-before-write.
  logic [13:0] ram_mem [16];
  logic [3:0]  ram_ra_q = '0;
  logic [13:0] ram_dout_q = '0;
  always @(posedge clk) begin
    if (ram_we)  ram_mem[ram_wa] <= ram_di;
    if (ram_re)  ram_ra_q <= ram_ra;
    if (ram_ore) ram_dout_q <= ram_mem[ram_ra_q];
  end
  assign ram_dout = ram_dout_q;

`ifdef SA_FIFO_CTRL_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: plain FIFO of accepted words plus occupancy and error flag.
  logic [13:0] exp_q [$];
  int          model_cnt  = 0;
  logic [3:0]  exp_wa     = '0;
  logic        err_model  = 1'b0;
  logic        prev_block = 1'b0;
  logic        mon_en     = 1'b0;
  int          phase_pops = 0;
  int          pop_first  = 0;
  int          pop_last   = 0;

  always @(negedge clk) begin
    logic        acc, pp;
    logic [13:0] e;
    if (mon_en) begin
      acc = wr_pvld && wr_prdy;
      pp  = rd_pvld && rd_prdy;
      check("fifo_count", fifo_count, model_cnt);
      check("fifo_err", fifo_err, err_model);
      check("ram_we", ram_we, acc);
      if (pp) begin
        if (exp_q.size() == 0) flag_fail("rd_unexpected_output");
        else begin
          e = exp_q.pop_front();
          check("rd_pd", rd_pd, e);
        end
        if (phase_pops == 0) pop_first = cyc;
        pop_last = cyc;
        phase_pops++;
      end
      if (acc) begin
        check("ram_wa", ram_wa, exp_wa);
        check("ram_di", ram_di, wr_pd);
        exp_q.push_back(wr_pd);
        exp_wa = exp_wa + 4'd1;
      end
      model_cnt = model_cnt + int'(acc) - int'(pp);
      if (ERR_ON && prev_block && !wr_pvld) err_model = 1'b1;
      prev_block = wr_pvld && !wr_prdy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [13:0] d, input int budget);
    bit ok;
    ok = 0;
    wr_pvld = 1'b1;
    wr_pd   = d;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_prdy) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    wr_pvld = 1'b0;
    if (!ok) flag_fail("wr_accept_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_prdy"}, wr_prdy, 0);
    check({tag, "_rd_pvld"}, rd_pvld, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_re"}, ram_re, 0);
    check({tag, "_ram_ore"}, ram_ore, 0);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_fifo_err"}, fifo_err, 0);
    check({tag, "_rd_pd"}, rd_pd, 0);
    check({tag, "_ram_di"}, ram_di, 0);
    check({tag, "_ram_wa"}, ram_wa, 0);
    check({tag, "_ram_ra"}, ram_ra, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_cnt  = 0;
    exp_wa     = '0;
    err_model  = 1'b0;
    prev_block = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int i;
    for (i = 0; i < budget && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) flag_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc_now;
    int   c0;
    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = 14'h1234; rd_prdy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");

    // Reset release
    tick();
    rstn = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    check("release_wr_prdy_low", wr_prdy, 0);
    tick();
    @(negedge clk);
    check("release_wr_prdy_high", wr_prdy, 1);
    check("release_rd_pvld", rd_pvld, 0);

    // Single entry latency
    tick();
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 14'h2A5F;
    @(negedge clk);
    check("single_we", ram_we, 1);
    check("single_wa", ram_wa, 0);
    tick(); wr_pvld = 1'b0;
    @(negedge clk);
    check("single_re_t1", ram_re, 1);
    check("single_ra_t1", ram_ra, 0);
    tick(); @(negedge clk);
    check("single_ore_t2", ram_ore, 1);
    tick(); @(negedge clk);
    check("single_rd_pvld_t3", rd_pvld, 0);
    tick(); @(negedge clk);
    check("single_rd_pvld_t4", rd_pvld, 1);
    check("single_rd_pd_t4", rd_pd, 14'h2A5F);
    tick();

    // Fill with consumer stalled, then drain without bubbles
    rd_prdy = 1'b0;
    for (int v = 1; v <= 19; v++) push_word(14'(v), 4);
    @(negedge clk);
    check("fill_wr_prdy", wr_prdy, 0);
    check("fill_count", fifo_count, 19);
    check("fill_head", rd_pd, 1);
    tick();
    rd_prdy = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      check("drain_no_bubble", rd_pvld, 1);
      tick();
    end
    @(negedge clk);
    check("drain_empty", rd_pvld, 0);
    tick();

    // Streaming with wrap
    phase_pops = 0;
    c0 = cyc;
    for (int k = 0; k < 40; k++) push_word(14'($urandom), 4);
    check("stream_accept_cycles", cyc - c0, 40);
    for (int i = 0; i < 60 && phase_pops < 40; i++) tick();
    check("stream_pops", phase_pops, 40);
    check("stream_pop_span", pop_last - pop_first, 39);

    // Random traffic with backpressure, producer holds valid until accepted
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc_now = wr_pvld && wr_prdy;
      tick();
      if (!wr_pvld || acc_now) begin
        wr_pvld = ($urandom_range(1, 0) == 1);
        wr_pd   = 14'($urandom);
      end
      rd_prdy = ($urandom_range(9, 0) >= 3);
    end
    rd_prdy = 1'b1;
    if (wr_pvld) push_word(wr_pd, 20);
    wait_drained("random_drain_timeout", 100);
    tick(); @(negedge clk);
    check("random_final_count", fifo_count, 0);
    tick();

    // Withdrawn valid while full
    rd_prdy = 1'b0;
    for (int v = 0; v < 19; v++) push_word(14'(16'h100 + v), 4);
    wr_pvld = 1'b1; wr_pd = 14'h3FFF;
    @(negedge clk);
    check("err_full_wr_prdy", wr_prdy, 0);
    tick(); wr_pvld = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("err_flag_set", fifo_err, ERR_ON);
    repeat (3) tick();
    @(negedge clk);
    check("err_flag_sticky", fifo_err, ERR_ON);

    // Reset mid-operation clears state asynchronously
    tick();
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    tick(); tick();
    rstn = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    check("rerelease_wr_prdy_low", wr_prdy, 0);
    tick(); @(negedge clk);
    check("rerelease_wr_prdy_high", wr_prdy, 1);
    tick();
    rd_prdy = 1'b1;
    push_word(14'h0155, 4);
    wait_drained("post_reset_drain_timeout", 20);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
